// File: rtl/timer_pkg.sv
// Shared types for the down-counting timer: FSM state encoding and
// a helper that sizes the prescaler counter.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // A one-bit counter is kept even for PRESCALE==1 so the divider never
  // degenerates into a zero-width vector.
  function automatic int prescale_w(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// PRESCALE-cycle divider: pulses tick on the cycle the phase counter
// reaches PRESCALE-1 while enabled; clr restarts the phase.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PS_W = prescale_w(PRESCALE);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q;
  logic [PS_W-1:0] cnt_d;
  logic            at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = en && !clr && at_last;

  // The phase is held, not cleared, while disabled so a pause resumes mid-period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / periodic modes, pause/resume
// and a clock prescaler; emits a registered one-cycle terminal-count pulse.
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q;
  logic             tick;
  logic             ps_en;

  // A stop in RUN must freeze the phase on the same edge it pauses the count.
  assign ps_en = (state_q == RUN) && !stop;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ps_en),
    .clr   (load),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = d;
      q_d      = d;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (start && (state_q != RUN)) begin
      if (q_q != '0) begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) && tick) begin
      if (q_q > WIDTH'(1)) begin
        q_d = q_q - WIDTH'(1);
      end else if (q_q == WIDTH'(1)) begin
        q_d  = '0;
        tc_d = 1'b1;
        if (!periodic) begin
          state_d = IDLE;
        end
      end else if (periodic) begin
        // Reaching zero reloads one tick later, so the period is reload+1 ticks.
        q_d = reload_q;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == RUN);
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign tc   = tc_q;

endmodule
